// File: rtl/csr_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : csr_bank_pkg
// Purpose  : Shared types and helpers for the csr_bank register bank.
//            - acc_e      : access class of an address
//            - decode_acc : maps an address onto its access class
//            - PEND_OFS / MASK_OFS : interrupt register offsets, relative to
//              the first address after the status block
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package csr_bank_pkg;

   typedef enum logic [1:0] {
      ACC_RW   = 2'd0,
      ACC_RO   = 2'd1,
      ACC_W1C  = 2'd2,
      ACC_NONE = 2'd3
   } acc_e;

   localparam int unsigned PEND_OFS = 0;
   localparam int unsigned MASK_OFS = 1;

   // The mask register is plain read/write storage, so it decodes as ACC_RW;
   // the top tells it apart from the control registers by its address.
   function automatic acc_e decode_acc(input logic [31:0] addr,
                                       input int unsigned num_rw,
                                       input int unsigned num_ro);
      acc_e acc;
      if (addr < num_rw)
         acc = ACC_RW;
      else if (addr < num_rw + num_ro)
         acc = ACC_RO;
      else if (addr == num_rw + num_ro + PEND_OFS)
         acc = ACC_W1C;
      else if (addr == num_rw + num_ro + MASK_OFS)
         acc = ACC_RW;
      else
         acc = ACC_NONE;
      return acc;
   endfunction

endpackage
`default_nettype wire

// File: rtl/csr_bank_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : csr_irq_ctrl
// Purpose  : Interrupt block of the register bank: W1C pending register,
//            read/write mask register and a registered interrupt request.
// Ports    : clk          in  system clock
//            rstb         in  asynchronous active-low reset
//            evt_i        in  event bits, level-sampled every cycle
//            clr_i        in  W1C clear vector (zero when no W1C write)
//            mask_we_i    in  mask write enable
//            mask_wdata_i in  mask write data
//            pend_o       out pending register
//            mask_o       out mask register
//            irq_o        out interrupt request
// Revision : 1.0 - initial release
// ============================================================================
module csr_irq_ctrl
   import csr_bank_pkg::*;
#(
   parameter int REG_W = 8
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic [REG_W-1:0] evt_i,
   input  logic [REG_W-1:0] clr_i,
   input  logic             mask_we_i,
   input  logic [REG_W-1:0] mask_wdata_i,
   output logic [REG_W-1:0] pend_o,
   output logic [REG_W-1:0] mask_o,
   output logic             irq_o
);

   logic [REG_W-1:0] pend_q, pend_d;
   logic [REG_W-1:0] mask_q, mask_d;
   logic             irq_q,  irq_d;

   // A new event in the same cycle as a clear of the same bit wins.
   // irq is computed from the next-state values so it follows an event or a
   // mask write by exactly one cycle.
   always_comb begin
      pend_d = (pend_q & ~clr_i) | evt_i;
      mask_d = mask_we_i ? mask_wdata_i : mask_q;
      irq_d  = |(pend_d & mask_d);
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         pend_q <= '0;
         mask_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         mask_q <= mask_d;
         irq_q  <= irq_d;
      end
   end

   assign pend_o = pend_q;
   assign mask_o = mask_q;
   assign irq_o  = irq_q;

endmodule
`default_nettype wire

// File: rtl/csr_bank.sv
`default_nettype none
// ============================================================================
// Module   : csr_bank
// Purpose  : Parametrised control/status register bank behind the SPI
//            application interface. NUM_RW control registers, NUM_RO status
//            words, a W1C pending / RW mask interrupt pair, and a registered
//            one-cycle ack/err/rdata response to every accepted request.
// Ports    : clk      in  system clock
//            rstb     in  asynchronous active-low reset
//            ena      in  block enable (requests ignored while low)
//            req      in  request strobe
//            wr_rdn   in  1 = write, 0 = read
//            addr     in  register address
//            wdata    in  write data
//            rdata    out read data, valid with ack
//            ack      out one-cycle response pulse
//            err      out error flag, valid with ack
//            ctrl_o   out control registers, reg i at [i*REG_W +: REG_W]
//            status_i in  status words, same packing
//            evt_i    in  interrupt event bits
//            irq      out registered interrupt request
// Revision : 1.0 - initial release
// ============================================================================
module csr_bank
   import csr_bank_pkg::*;
#(
   parameter int               ADDR_W  = 8,
   parameter int               REG_W   = 8,
   parameter int               NUM_RW  = 4,
   parameter int               NUM_RO  = 2,
   parameter logic [REG_W-1:0] RST_VAL = '0
) (
   input  logic                    clk,
   input  logic                    rstb,
   input  logic                    ena,
   input  logic                    req,
   input  logic                    wr_rdn,
   input  logic [ADDR_W-1:0]       addr,
   input  logic [REG_W-1:0]        wdata,
   output logic [REG_W-1:0]        rdata,
   output logic                    ack,
   output logic                    err,
   output logic [NUM_RW*REG_W-1:0] ctrl_o,
   input  logic [NUM_RO*REG_W-1:0] status_i,
   input  logic [REG_W-1:0]        evt_i,
   output logic                    irq
);

   generate
      if (longint'(NUM_RW + NUM_RO + 2) > (longint'(1) << ADDR_W)) begin : g_param_check
         $error("csr_bank: register map does not fit in ADDR_W address bits");
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------------
   logic [31:0]       addr_ext;
   logic              accepted;
   logic              is_mask;
   acc_e              acc_type;
   logic [NUM_RW-1:0] ctrl_we;
   logic [REG_W-1:0]  w1c_clr;
   logic              mask_we;

   assign addr_ext = 32'(addr);
   assign accepted = req & ena;
   assign acc_type = decode_acc(addr_ext, NUM_RW, NUM_RO);
   assign is_mask  = (addr_ext == 32'(NUM_RW + NUM_RO + MASK_OFS));
   assign w1c_clr  = (accepted && wr_rdn && (acc_type == ACC_W1C)) ? wdata : '0;
   assign mask_we  = accepted && wr_rdn && is_mask;

   always_comb begin
      ctrl_we = '0;
      for (int i = 0; i < NUM_RW; i++) begin
         ctrl_we[i] = accepted && wr_rdn && (addr_ext == 32'(i));
      end
   end

   // ------------------------------------------------------------------------
   // Control registers
   // ------------------------------------------------------------------------
   logic [REG_W-1:0] ctrl_q [NUM_RW];

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         for (int i = 0; i < NUM_RW; i++) begin
            ctrl_q[i] <= RST_VAL;
         end
      end else begin
         for (int i = 0; i < NUM_RW; i++) begin
            if (ctrl_we[i]) begin
               ctrl_q[i] <= wdata;
            end
         end
      end
   end

   generate
      for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrl_out
         assign ctrl_o[g*REG_W +: REG_W] = ctrl_q[g];
      end
   endgenerate

   logic [REG_W-1:0] status_w [NUM_RO];

   generate
      for (genvar g = 0; g < NUM_RO; g++) begin : g_status
         assign status_w[g] = status_i[g*REG_W +: REG_W];
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Interrupt block
   // ------------------------------------------------------------------------
   logic [REG_W-1:0] irq_pend;
   logic [REG_W-1:0] irq_mask;

   csr_irq_ctrl #(
      .REG_W (REG_W)
   ) u_irq (
      .clk          (clk),
      .rstb         (rstb),
      .evt_i        (evt_i),
      .clr_i        (w1c_clr),
      .mask_we_i    (mask_we),
      .mask_wdata_i (wdata),
      .pend_o       (irq_pend),
      .mask_o       (irq_mask),
      .irq_o        (irq)
   );

   // ------------------------------------------------------------------------
   // Response
   // ------------------------------------------------------------------------
   logic [REG_W-1:0] rdata_q, rdata_d;
   logic             ack_q,   ack_d;
   logic             err_q,   err_d;

   // rdata only moves on an accepted read (or an unmapped read, which zeroes
   // it); writes and idle cycles leave the last read value in place.
   always_comb begin
      rdata_d = rdata_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      if (accepted) begin
         ack_d = 1'b1;
         case (acc_type)
            ACC_RW: begin
               if (!wr_rdn) begin
                  if (is_mask) begin
                     rdata_d = irq_mask;
                  end else begin
                     for (int i = 0; i < NUM_RW; i++) begin
                        if (addr_ext == 32'(i)) begin
                           rdata_d = ctrl_q[i];
                        end
                     end
                  end
               end
            end
            ACC_RO: begin
               if (wr_rdn) begin
                  err_d = 1'b1;
               end else begin
                  for (int i = 0; i < NUM_RO; i++) begin
                     if (addr_ext == 32'(NUM_RW + i)) begin
                        rdata_d = status_w[i];
                     end
                  end
               end
            end
            ACC_W1C: begin
               if (!wr_rdn) begin
                  rdata_d = irq_pend;
               end
            end
            default: begin
               err_d = 1'b1;
               if (!wr_rdn) begin
                  rdata_d = '0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         rdata_q <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         rdata_q <= rdata_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   assign rdata = rdata_q;
   assign ack   = ack_q;
   assign err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_bank
// Purpose  : Self-checking bench for csr_bank (REG_W=8, NUM_RW=4, NUM_RO=2,
//            PEND_A=6, MASK_A=7). Directed scenarios followed by random
//            traffic, all compared against a behavioural register-map model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_bank;

   logic        clk = 1'b0;
   logic        rstb;
   logic        ena;
   logic        req;
   logic        wr_rdn;
   logic [7:0]  addr;
   logic [7:0]  wdata;
   logic [7:0]  rdata;
   logic        ack;
   logic        err;
   logic [31:0] ctrl_o;
   logic [15:0] status_i;
   logic [7:0]  evt_i;
   logic        irq;

   always #5 clk = ~clk;

   csr_bank #(
      .ADDR_W  (8),
      .REG_W   (8),
      .NUM_RW  (4),
      .NUM_RO  (2),
      .RST_VAL (8'h00)
   ) dut (
      .clk      (clk),
      .rstb     (rstb),
      .ena      (ena),
      .req      (req),
      .wr_rdn   (wr_rdn),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .ack      (ack),
      .err      (err),
      .ctrl_o   (ctrl_o),
      .status_i (status_i),
      .evt_i    (evt_i),
      .irq      (irq)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: the register map as plain storage.
   logic [7:0] m_ctrl [4];
   logic [7:0] m_mask;
   logic [7:0] m_pend;
   logic [7:0] m_rd;
   logic       m_ack;
   logic       m_err;
   logic       m_irq;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_ctrl[i] = 8'h00;
      m_mask = 8'h00;
      m_pend = 8'h00;
      m_rd   = 8'h00;
      m_ack  = 1'b0;
      m_err  = 1'b0;
      m_irq  = 1'b0;
   endtask

   // One clock edge of the register map, using the inputs currently driven.
   task automatic model_step();
      logic [7:0] clr;
      logic [7:0] new_mask;
      clr      = 8'h00;
      new_mask = m_mask;
      m_ack    = req && ena;
      m_err    = 1'b0;
      if (req && ena) begin
         if (addr < 8'd4) begin
            if (wr_rdn) m_ctrl[addr[1:0]] = wdata;
            else        m_rd = m_ctrl[addr[1:0]];
         end else if (addr < 8'd6) begin
            if (wr_rdn) m_err = 1'b1;
            else        m_rd = (addr == 8'd4) ? status_i[7:0] : status_i[15:8];
         end else if (addr == 8'd6) begin
            if (wr_rdn) clr = wdata;
            else        m_rd = m_pend;
         end else if (addr == 8'd7) begin
            if (wr_rdn) new_mask = wdata;
            else        m_rd = m_mask;
         end else begin
            m_err = 1'b1;
            if (!wr_rdn) m_rd = 8'h00;
         end
      end
      m_pend = (m_pend & ~clr) | evt_i;
      m_mask = new_mask;
      m_irq  = |(m_pend & m_mask);
   endtask

   task automatic check_all();
      check_eq("ack",    ack,    m_ack);
      check_eq("err",    err,    m_err);
      check_eq("rdata",  rdata,  m_rd);
      check_eq("irq",    irq,    m_irq);
      check_eq("ctrl_o", ctrl_o, {m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]});
   endtask

   task automatic step(input logic e, input logic r, input logic w,
                       input logic [7:0] a, input logic [7:0] d, input logic [7:0] ev);
      @(negedge clk);
      ena    = e;
      req    = r;
      wr_rdn = w;
      addr   = a;
      wdata  = d;
      evt_i  = ev;
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r;
      rstb     = 1'b0;
      ena      = 1'b0;
      req      = 1'b0;
      wr_rdn   = 1'b0;
      addr     = 8'h00;
      wdata    = 8'h00;
      evt_i    = 8'h00;
      status_i = 16'h3C81;
      model_reset();

      // Reset state
      #12;
      check_all();
      @(negedge clk);
      rstb = 1'b1;

      // Reset values read back from every control register
      for (int a = 0; a < 4; a++) begin
         step(1'b1, 1'b1, 1'b0, 8'(a), 8'h00, 8'h00);
         check_eq("rst_rd", rdata, 8'h00);
      end
      check_eq("rst_ctrl", ctrl_o, 32'h0);

      // Write then immediate read-back
      step(1'b1, 1'b1, 1'b1, 8'd2, 8'hA5, 8'h00);
      check_eq("wr_ctrl2", ctrl_o[23:16], 8'hA5);
      check_eq("wr_ack", ack, 1'b1);
      step(1'b1, 1'b1, 1'b0, 8'd2, 8'h00, 8'h00);
      check_eq("rb_data", rdata, 8'hA5);
      check_eq("rb_ack", ack, 1'b1);

      // Status reads and a rejected write to status
      step(1'b1, 1'b1, 1'b0, 8'd4, 8'h00, 8'h00);
      check_eq("st4", rdata, 8'h81);
      step(1'b1, 1'b1, 1'b0, 8'd5, 8'h00, 8'h00);
      check_eq("st5", rdata, 8'h3C);
      step(1'b1, 1'b1, 1'b1, 8'd5, 8'hFF, 8'h00);
      check_eq("st_wr_err", err, 1'b1);
      check_eq("st_wr_rd", rdata, 8'h3C);
      step(1'b1, 1'b1, 1'b0, 8'd5, 8'h00, 8'h00);
      check_eq("st5_again", rdata, 8'h3C);

      // Unmapped accesses
      step(1'b1, 1'b1, 1'b0, 8'h20, 8'h00, 8'h00);
      check_eq("unm_rd_err", err, 1'b1);
      check_eq("unm_rd_data", rdata, 8'h00);
      step(1'b1, 1'b1, 1'b1, 8'h20, 8'h5A, 8'h00);
      check_eq("unm_wr_err", err, 1'b1);
      check_eq("unm_wr_ctrl", ctrl_o, 32'h00A5_0000);

      // Interrupts
      step(1'b1, 1'b0, 1'b0, 8'd0, 8'h00, 8'h04);
      check_eq("irq_masked", irq, 1'b0);
      step(1'b1, 1'b1, 1'b0, 8'd6, 8'h00, 8'h00);
      check_eq("pend_rd", rdata, 8'h04);
      step(1'b1, 1'b1, 1'b1, 8'd7, 8'h04, 8'h00);
      check_eq("irq_unmask", irq, 1'b1);
      step(1'b1, 1'b1, 1'b1, 8'd6, 8'h04, 8'h00);
      check_eq("irq_w1c", irq, 1'b0);
      step(1'b1, 1'b1, 1'b0, 8'd6, 8'h00, 8'h00);
      check_eq("pend_clr", rdata, 8'h00);
      step(1'b1, 1'b1, 1'b1, 8'd6, 8'h04, 8'h04);
      step(1'b1, 1'b1, 1'b0, 8'd6, 8'h00, 8'h00);
      check_eq("set_wins", rdata, 8'h04);
      check_eq("set_wins_irq", irq, 1'b1);

      // Disabled block ignores requests
      step(1'b0, 1'b1, 1'b1, 8'd0, 8'h77, 8'h00);
      check_eq("dis_ack", ack, 1'b0);
      check_eq("dis_ctrl0", ctrl_o[7:0], 8'h00);

      // Reset in the middle of a response cycle
      @(negedge clk);
      ena    = 1'b1;
      req    = 1'b1;
      wr_rdn = 1'b0;
      addr   = 8'd2;
      evt_i  = 8'h00;
      @(posedge clk);
      model_step();
      #1;
      check_all();
      req = 1'b0;
      #2;
      rstb = 1'b0;
      #1;
      model_reset();
      check_all();
      check_eq("mid_rst_ack", ack, 1'b0);
      check_eq("mid_rst_irq", irq, 1'b0);
      check_eq("mid_rst_ctrl", ctrl_o, 32'h0);
      @(negedge clk);
      rstb = 1'b1;

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 15);
         if ($urandom_range(0, 7) == 0) status_i = 16'($urandom);
         step(($urandom_range(0, 9) != 0),
              ($urandom_range(0, 9) < 7),
              1'($urandom),
              (r < 10) ? 8'(r) : ((r < 13) ? 8'h20 : 8'($urandom)),
              8'($urandom),
              ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
